// File: rtl/beat_slot_sequencer.sv
// beat_slot_sequencer: records the live key stream as (ascii, duration) events into one of
// three slots of a shared RAM and replays a slot. Define BEAT_LOOP_PLAYBACK_EN to loop playback.
module beat_slot_sequencer #(
    parameter int TICK_DIV = 500000,
    parameter int DEPTH    = 64,
    parameter int DUR_W    = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [6:0]             ascii_in,
    input  logic                   record_n,
    input  logic                   play_n,
    input  logic [2:0]             slot_sw,
    output logic [6:0]             play_ascii,
    output logic [1:0]             play_slot,
    output logic                   recording,
    output logic                   playing,
    output logic [2:0]             slot_valid,
    output logic [$clog2(DEPTH):0] event_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;
    localparam logic [CW-1:0]    FULL    = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, REC, REC_FLUSH, PLAY_FETCH, PLAY} state_t;
    state_t state;

    logic            rec_q, play_q;
    logic            rec_press, play_press;
    logic [TW-1:0]   tcnt;
    logic            tick;
    logic [1:0]      sel, slot;
    logic            sel_ok, start_rec;
    logic [6:0]      cur_ascii;
    logic [DUR_W-1:0] dur, remaining;
    logic [CW-1:0]   wr_ptr, rd_ptr, last_len, rec_len, next_rd;
    logic [CW-1:0]   slot_len [0:2];
    logic            rec_stop, rec_change, flush_has, rec_we, slot_done;
    logic [6+DUR_W:0] ram [0:3*DEPTH-1];

    assign rec_press  = rec_q & ~record_n;
    assign play_press = play_q & ~play_n;
    assign tick       = (tcnt == TW'(TICK_DIV - 1));
    assign sel_ok     = |slot_sw;
    assign sel        = slot_sw[0] ? 2'd0 : (slot_sw[1] ? 2'd1 : 2'd2);
    assign start_rec  = rec_press && sel_ok &&
                        (state == IDLE || state == PLAY_FETCH || state == PLAY);

    assign rec_stop   = (wr_ptr == FULL) || rec_press;
    assign rec_change = !((ascii_in == cur_ascii) && (dur != DUR_MAX));
    assign flush_has  = (wr_ptr != FULL) && (dur != '0);
    assign rec_len    = flush_has ? wr_ptr + 1'b1 : wr_ptr;
    // A zero-duration pending entry never reaches the RAM.
    assign rec_we     = ((state == REC) && !rec_stop && tick && rec_change && (dur != '0)) ||
                        ((state == REC_FLUSH) && flush_has);

`ifdef BEAT_LOOP_PLAYBACK_EN
    assign next_rd   = (rd_ptr + 1'b1 == slot_len[slot]) ? '0 : rd_ptr + 1'b1;
    assign slot_done = 1'b0;
`else
    assign next_rd   = rd_ptr + 1'b1;
    assign slot_done = (rd_ptr == slot_len[slot]);
`endif

    always_ff @(posedge clk) begin
        if (rec_we)
            ram[{slot, wr_ptr[PW-1:0]}] <= {cur_ascii, dur};
    end

    always_comb begin
        case (state)
            REC, REC_FLUSH:   event_count = wr_ptr;
            PLAY_FETCH, PLAY: event_count = rd_ptr;
            default:          event_count = last_len;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            rec_q      <= 1'b1;
            play_q     <= 1'b1;
            tcnt       <= '0;
            slot       <= '0;
            cur_ascii  <= '0;
            dur        <= '0;
            remaining  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_len   <= '0;
            for (int i = 0; i < 3; i++) slot_len[i] <= '0;
            play_ascii <= '0;
            play_slot  <= 2'd3;
            recording  <= 1'b0;
            playing    <= 1'b0;
            slot_valid <= '0;
        end else begin
            rec_q  <= record_n;
            play_q <= play_n;
            tcnt   <= tick ? '0 : tcnt + 1'b1;
            if (start_rec) begin
                // Record wins over an active playback, even on the same slot.
                state      <= REC;
                slot       <= sel;
                cur_ascii  <= ascii_in;
                dur        <= '0;
                wr_ptr     <= '0;
                tcnt       <= '0;
                recording  <= 1'b1;
                playing    <= 1'b0;
                play_ascii <= '0;
                play_slot  <= 2'd3;
            end else begin
                case (state)
                    IDLE: if (play_press && sel_ok && slot_valid[sel]) begin
                        state     <= PLAY_FETCH;
                        slot      <= sel;
                        play_slot <= sel;
                        rd_ptr    <= '0;
                        tcnt      <= '0;
                        last_len  <= slot_len[sel];
                    end
                    REC: begin
                        if (rec_stop) begin
                            state     <= REC_FLUSH;
                            recording <= 1'b0;
                        end else if (tick) begin
                            if (!rec_change) begin
                                dur <= dur + 1'b1;
                            end else begin
                                if (dur != '0) wr_ptr <= wr_ptr + 1'b1;
                                cur_ascii <= ascii_in;
                                dur       <= DUR_W'(1);
                            end
                        end
                    end
                    REC_FLUSH: begin
                        state            <= IDLE;
                        wr_ptr           <= rec_len;
                        slot_len[slot]   <= rec_len;
                        slot_valid[slot] <= (rec_len != '0);
                        last_len         <= rec_len;
                    end
                    PLAY_FETCH: begin
                        if (play_press || slot_done) begin
                            state      <= IDLE;
                            play_ascii <= '0;
                            play_slot  <= 2'd3;
                            playing    <= 1'b0;
                        end else begin
                            {play_ascii, remaining} <= ram[{slot, rd_ptr[PW-1:0]}];
                            playing <= 1'b1;
                            state   <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (play_press) begin
                            state      <= IDLE;
                            play_ascii <= '0;
                            play_slot  <= 2'd3;
                            playing    <= 1'b0;
                        end else if (tick) begin
                            remaining <= remaining - 1'b1;
                            // Tick phase restarts at each fetch so every event lasts dur ticks.
                            if (remaining <= DUR_W'(1)) begin
                                rd_ptr <= next_rd;
                                tcnt   <= '0;
                                state  <= PLAY_FETCH;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/beat_slot_sequencer.md
Name: beat_slot_sequencer

Overview:
- Record/playback controller between the PS/2 ascii decoder and the buzzer players.
- Captures the live key stream into one of three saved-recording slots as (ascii, duration) events.
- Replays a selected slot as an ascii stream for the slot buzzer.
- Owns a single shared event RAM. Arbitrates record vs playback access and sequences both with one FSM.

Parameters:
- TICK_DIV, 500000: clk cycles per timing tick (10 ms at 50 MHz).
- DEPTH, 64: events per slot (power of 2); RAM holds 3*DEPTH entries.
- DUR_W, 8: duration field width in ticks.

Ports:
- clk  input  1  system clock (CLOCK_50 at top)
- resetn  input  1  synchronous active-low reset
- ascii_in  input  7  current key ascii from decoder; 0 = no key
- record_n  input  1  record button, active-low level (KEY[0])
- play_n  input  1  play button, active-low level (KEY[1])
- slot_sw  input  3  slot select switches (SW[2:0])
- play_ascii  output  7  ascii being replayed; 0 when not playing
- play_slot  output  2  slot index being replayed (0..2); 3 when idle
- recording  output  1  high in REC state
- playing  output  1  high in PLAY state
- slot_valid  output  3  bit n set when slot n holds ≥1 event
- event_count  output  log2(DEPTH)+1  events in the active slot (being written or read)

Behaviour:
- Reset (resetn=0 at clk edge): FSM=IDLE; play_ascii=0; play_slot=3; recording=0; playing=0; slot_valid=0; event_count=0; tick counter=0; button edge registers=1. RAM contents are don't-care because slot_valid gates them.
- Buttons: record_n/play_n are registered once. A press is a 1→0 transition, giving a one-cycle internal pulse. Held buttons do not repeat.
- Slot decode: priority SW[0]>SW[1]>SW[2] gives slot 0/1/2. No switch set means no slot, and all presses are ignored in IDLE.
- Tick: free-running counter 0..TICK_DIV-1. tick=1 for one cycle at wrap. Counter restarts at 0 on every REC or PLAY entry.
- States: IDLE, REC, REC_FLUSH, PLAY_FETCH, PLAY.
- IDLE + record press + slot valid → REC:
  - latch slot, cur_ascii=ascii_in, dur=0, wr_ptr=0.
  - recording=1 the cycle after the press.
- REC, each tick: if ascii_in==cur_ascii and dur<2^DUR_W-1, then dur++. Otherwise write {cur_ascii,dur}, wr_ptr++, cur_ascii=ascii_in, dur=1.
  - Duration saturation produces a new event with the same ascii.
  - Entries with dur=0 are never written.
- REC + record press → REC_FLUSH: write the pending entry if dur>0, set slot length=wr_ptr (post-write), then → IDLE.
  - slot_valid[slot] = (length>0); a zero-length recording clears the bit.
- REC with wr_ptr reaches DEPTH (slot full) → immediate REC_FLUSH without a further write. The pending event is dropped; length=DEPTH.
- REC + play press: ignored. Switch changes during REC: ignored (slot latched).
- IDLE + play press + slot valid + slot_valid[slot]=1 → PLAY_FETCH. If slot_valid is 0, ignored.
- PLAY_FETCH: issue RAM read at rd_ptr (1-cycle read latency), then → PLAY.
  - Load play_ascii and remaining=dur; playing=1.
  - play_ascii updates 2 cycles after the press for the first event.
- PLAY: decrement remaining on each tick. When remaining hits 0: rd_ptr++ → PLAY_FETCH, or end-of-slot handling when rd_ptr==length.
- PLAY + play press → IDLE: play_ascii=0, play_slot=3, playing=0 the next cycle.
- PLAY + record press → stop playback and enter REC on the same press (record wins). If the recorded slot equals the playing slot, its old contents are overwritten.
- RAM arbitration: single port. REC writes and PLAY reads are mutually exclusive by FSM. No simultaneous access possible.
- event_count: wr_ptr in REC, rd_ptr in PLAY, length of the last-used slot in IDLE.

Optional Feature:
- Macro: BEAT_LOOP_PLAYBACK_EN.
- Defined: at end of slot, rd_ptr=0 → PLAY_FETCH. Playback loops until a play or record press.
- Undefined: at end of slot → IDLE, outputs return to idle values one cycle later.

Test Plan:
- TICK_DIV=4, DEPTH=4, DUR_W=4. Sequence: SW=001, press record, ascii 'a'(0x61) for 12 ticks, 's'(0x73) for 5 ticks, press record → slot_valid=001, event_count=2, RAM[0]={0x61,12}, RAM[1]={0x73,5}.
- Play the above without LOOP → play_ascii=0x61 for 48 cycles, then 0x73 for 20 cycles, then 0. playing falls; play_slot=3.
- Hold 'a' 40 ticks in slot 1 (SW=010) → events {0x61,15},{0x61,15},{0x61,10}; slot_valid=010.
- Record 6 distinct keys into slot 2 → auto-stop after 4 events; recording=0 without a button press; event_count=4.
- Press then release record within 1 tick on slot 0 → slot_valid[0] cleared to 0. A later play press with SW=001 is ignored.
- During looped playback (BEAT_LOOP_PLAYBACK_EN), press record with SW=001 → playing=0 and recording=1 on the next cycle. Assert resetn=0 mid-REC → all outputs at reset values next edge; slot_valid=000.
